// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared RV32I constants and the fetch entry type
// Purpose: XLEN, the canonical NOP and base opcodes shared by fetch and the
//          controller, plus the {pc, instr} record buffered by fetch.
// Ports:   none (package).
package instr_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory request/response channel
// Purpose: groups the fetch-to-imem request (valid/ready/addr) and the
//          in-order, never back-pressured response (valid/data).
// Modports: master - fetch side (drives request, receives response)
//           slave  - memory side (accepts request, drives response)
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - fetch_fifo: small synchronous prefetch FIFO
// Purpose: DEPTH-entry FIFO with flush; head is read straight from storage.
// Ports:   clk, rst (sync, active high), flush, push/push_data, pop,
//          head, empty, full, count.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: PC, credit-limited imem fetch, prefetch FIFO
// Purpose: issues word fetches from pc, buffers responses tagged with their pc,
//          hands {instr, pc} to decode, flushes on EX redirect.
// Ports:   clk, rst (sync, active high); imem (instr_fetch_if.master);
//          redirect_valid/redirect_pc from EX; id_valid/id_ready/id_instr/id_pc
//          towards decode.
// Config:  FETCH_BYPASS_EN - a response arriving while nothing is buffered
//          drives the decode outputs in the same cycle.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      imem,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_instr,
  output logic [XLEN-1:0]    id_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;   // live fetches still owed by memory
  logic [CW-1:0]   drop_cnt;      // stale fetches whose responses get discarded
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] tag_q [DEPTH]; // pc of every fetch in flight, in issue order
  logic [AW-1:0]   tag_wr;
  logic [AW-1:0]   tag_rd;
  logic [XLEN-1:0] rsp_pc;
  logic [SW-1:0]   credit_used;
  logic            req_hs;
  logic            rsp_live;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    fifo_head;

  assign rsp_pc   = tag_q[tag_rd];
  // Anything returning in a redirect cycle belongs to the old path.
  assign rsp_live = imem.imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign fifo_pop = !fifo_empty && id_ready && !redirect_valid;

  // Stale fetches keep holding credit until their responses drain; a slot
  // freed by this cycle's pop can be reused at once to sustain 1 fetch/cycle.
  assign credit_used = SW'(outstanding) + SW'(drop_cnt) + SW'(fifo_count) - SW'(fifo_pop);
  assign imem.imem_req_valid = !rst && (credit_used < SW'(DEPTH));
  assign imem.imem_req_addr  = pc;
  assign req_hs = imem.imem_req_valid && imem.imem_req_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_live && fifo_empty;
  assign fifo_push = rsp_live && !(bypass && id_ready);
`else
  assign fifo_push = rsp_live;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data ({rsp_pc, imem.imem_rsp_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    id_valid = !fifo_empty;
    id_instr = INSTR_NOP;
    id_pc    = '0;
    if (!fifo_empty) begin
      id_instr = fifo_head.instr;
      id_pc    = fifo_head.pc;
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass) begin
      id_valid = 1'b1;
      id_instr = imem.imem_rsp_data;
      id_pc    = rsp_pc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (req_hs)              tag_wr <= tag_wr + 1'b1;
      // Dropped responses still consume their tag so the queue stays aligned.
      if (imem.imem_rsp_valid) tag_rd <= tag_rd + 1'b1;
      if (redirect_valid) begin
        pc          <= redirect_pc;
        outstanding <= '0;
        // Every fetch still in flight after this cycle, old drops included.
        drop_cnt    <= outstanding + drop_cnt + CW'(req_hs) - CW'(imem.imem_rsp_valid);
      end else begin
        if (req_hs) pc <= pc + 32'd4;
        outstanding <= outstanding + CW'(req_hs)
                       - CW'(imem.imem_rsp_valid && (drop_cnt == '0));
        drop_cnt    <= drop_cnt - CW'(imem.imem_rsp_valid && (drop_cnt != '0));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs && !rst) tag_q[tag_wr] <= pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
      assert (outstanding <= CW'(DEPTH));
      assert (!redirect_valid || (redirect_pc[1:0] == 2'b00));
    end
  end

endmodule
